stopwatch_ctrl: RTL and testbench

Stopwatch sequencing controller. It consumes the divided clock levels from the project clock divider: 1 Hz count, 2 Hz adjust and 4 Hz blink. It converts them to single-cycle enables in the sys_clk domain and runs an MM:SS BCD count with run, pause, clear and adjust modes. It sits between the clock divider/button debouncers and the 7-segment display driver, and supplies the digit values and per-digit blank mask.

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/bcd_digit_counter.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 141 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller and its BCD digit counters.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   localparam int DIGIT_W      = 4;
   localparam int SEC_TENS_MAX = 5;
   localparam int SEC_ONES_MAX = 9;

   // digit_blank bit positions, MSB is the leftmost display digit
   localparam int BLANK_MIN_TENS = 3;
   localparam int BLANK_MIN_ONES = 2;
   localparam int BLANK_SEC_TENS = 1;
   localparam int BLANK_SEC_ONES = 0;

   function automatic logic [3:0] field_mask(input logic sel_sec);
      logic [3:0] mask;
      mask = '0;
      if (sel_sec) begin
         mask[BLANK_SEC_TENS] = 1'b1;
         mask[BLANK_SEC_ONES] = 1'b1;
      end else begin
         mask[BLANK_MIN_TENS] = 1'b1;
         mask[BLANK_MIN_ONES] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single mod-N BCD digit: clr beats inc, carry is high on the inc that wraps N-1 to 0.
// Latency: count registered, carry combinational from inc. No backpressure.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int N = 10
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] cnt,
   output logic               carry
);

   localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(N - 1);

   always_ff @(posedge sys_clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;
      end
   end

   assign carry = inc & (cnt == TOP);

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch sequencer (run/pause/clear/adjust); STOPWATCH_LAP_EN adds a lap-hold snapshot.
// Latency: divider edges and buttons are reflected on outputs one sys_clk after being sampled.
// Backpressure: none; every input is consumed in the cycle it is sampled.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_WRAP     = 99,
   parameter bit START_PAUSED = 1'b0
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       onehz_clk,
   input  logic       twohz_clk,
   input  logic       blink_clk,
   input  logic       pause_btn,
   input  logic       clear_btn,
   input  logic       adj,
   input  logic       sel,
   input  logic       lap_btn,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] digit_blank,
   output logic       running
);

   localparam state_t             RESET_STATE = START_PAUSED ? ST_PAUSED : ST_RUN;
   localparam logic [DIGIT_W-1:0] WRAP_TENS   = DIGIT_W'(MIN_WRAP / 10);
   localparam logic [DIGIT_W-1:0] WRAP_ONES   = DIGIT_W'(MIN_WRAP % 10);

   logic   prev1, prev2, prev_blink;
   logic   tick1, tick2;
   state_t state_q, state_nxt;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         prev1      <= 1'b0;
         prev2      <= 1'b0;
         prev_blink <= 1'b0;
      end else begin
         prev1      <= onehz_clk;
         prev2      <= twohz_clk;
         prev_blink <= blink_clk;
      end
   end

   assign tick1 = onehz_clk & ~prev1;
   assign tick2 = twohz_clk & ~prev2;

   always_ff @(posedge sys_clk) begin
      if (rst) state_q <= RESET_STATE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RUN: begin
            if (adj)            state_nxt = ST_ADJUST;
            else if (pause_btn) state_nxt = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (adj)            state_nxt = ST_ADJUST;
            else if (pause_btn) state_nxt = ST_RUN;
         end
         ST_ADJUST: begin
            if (!adj)           state_nxt = ST_PAUSED;
         end
         default:               state_nxt = RESET_STATE;
      endcase
   end

   logic [DIGIT_W-1:0] live_mt, live_mo, live_st, live_so;
   logic               so_carry, st_carry, mo_carry, mt_carry_unused;
   logic               sec_inc, min_inc, min_at_wrap, min_clr;

   // Adjust increments one field only: seconds carry never reaches minutes outside RUN.
   assign sec_inc     = ((state_q == ST_RUN) & tick1) | ((state_q == ST_ADJUST) & tick2 & sel);
   assign min_inc     = ((state_q == ST_RUN) & st_carry) | ((state_q == ST_ADJUST) & tick2 & ~sel);
   assign min_at_wrap = (live_mt == WRAP_TENS) && (live_mo == WRAP_ONES);
   assign min_clr     = clear_btn | (min_inc & min_at_wrap);

   bcd_digit_counter #(.N(SEC_ONES_MAX + 1)) u_sec_ones (
      .sys_clk(sys_clk), .rst(rst), .clr(clear_btn), .inc(sec_inc),
      .cnt(live_so), .carry(so_carry)
   );

   bcd_digit_counter #(.N(SEC_TENS_MAX + 1)) u_sec_tens (
      .sys_clk(sys_clk), .rst(rst), .clr(clear_btn), .inc(so_carry),
      .cnt(live_st), .carry(st_carry)
   );

   bcd_digit_counter #(.N(10)) u_min_ones (
      .sys_clk(sys_clk), .rst(rst), .clr(min_clr), .inc(min_inc),
      .cnt(live_mo), .carry(mo_carry)
   );

   bcd_digit_counter #(.N(10)) u_min_tens (
      .sys_clk(sys_clk), .rst(rst), .clr(min_clr), .inc(mo_carry),
      .cnt(live_mt), .carry(mt_carry_unused)
   );

   always_ff @(posedge sys_clk) begin
      if (rst)                                      digit_blank <= '0;
      else if ((state_nxt == ST_ADJUST) && blink_clk) digit_blank <= field_mask(sel);
      else                                          digit_blank <= '0;
   end

   assign running = (state_q == ST_RUN);

   logic [4*DIGIT_W-1:0] live;
   assign live = {live_mt, live_mo, live_st, live_so};

`ifdef STOPWATCH_LAP_EN
   logic                 lap_hold;
   logic [4*DIGIT_W-1:0] snap;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         lap_hold <= 1'b0;
         snap     <= '0;
      end else if (clear_btn || (state_nxt == ST_ADJUST)) begin
         lap_hold <= 1'b0;
      end else if (lap_btn && (state_q != ST_ADJUST)) begin
         lap_hold <= ~lap_hold;
         if (!lap_hold) snap <= live;
      end
   end

   assign {min_tens, min_ones, sec_tens, sec_ones} = lap_hold ? snap : live;
`else
   logic lap_unused;
   assign lap_unused = lap_btn;
   assign {min_tens, min_ones, sec_tens, sec_ones} = live;
`endif

   logic blink_unused;
   assign blink_unused = prev_blink;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one default instance plus a MIN_WRAP=1, START_PAUSED=1 instance.
module tb_stopwatch_ctrl;

   logic sys_clk = 1'b0;
   logic rst = 1'b1;
   logic onehz_clk = 1'b0, twohz_clk = 1'b0, blink_clk = 1'b0;
   logic pause_btn = 1'b0, pause2 = 1'b0, clear_btn = 1'b0;
   logic adj = 1'b0, sel = 1'b0, lap_btn = 1'b0;

   logic [3:0] mt, mo, st, so, blank;
   logic       run;
   logic [3:0] mt2, mo2, st2, so2, blank2;
   logic       run2;

   wire [15:0] disp  = {mt, mo, st, so};
   wire [15:0] disp2 = {mt2, mo2, st2, so2};

   int vectors = 0;
   int miscompares = 0;

   always #5 sys_clk = ~sys_clk;

   stopwatch_ctrl dut (
      .sys_clk(sys_clk), .rst(rst), .onehz_clk(onehz_clk), .twohz_clk(twohz_clk),
      .blink_clk(blink_clk), .pause_btn(pause_btn), .clear_btn(clear_btn),
      .adj(adj), .sel(sel), .lap_btn(lap_btn),
      .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
      .digit_blank(blank), .running(run)
   );

   stopwatch_ctrl #(.MIN_WRAP(1), .START_PAUSED(1'b1)) dut2 (
      .sys_clk(sys_clk), .rst(rst), .onehz_clk(onehz_clk), .twohz_clk(twohz_clk),
      .blink_clk(blink_clk), .pause_btn(pause2), .clear_btn(clear_btn),
      .adj(adj), .sel(sel), .lap_btn(lap_btn),
      .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
      .digit_blank(blank2), .running(run2)
   );

   task automatic do_reset();
      @(negedge sys_clk) rst = 1'b1;
      @(negedge sys_clk) rst = 1'b0;
   endtask

   task automatic tick1hz(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk) onehz_clk = 1'b1;
         @(negedge sys_clk) onehz_clk = 1'b0;
      end
   endtask

   task automatic tick2hz(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk) twohz_clk = 1'b1;
         @(negedge sys_clk) twohz_clk = 1'b0;
      end
   endtask

   task automatic press_pause();
      @(negedge sys_clk) pause_btn = 1'b1;
      @(negedge sys_clk) pause_btn = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge sys_clk);
      rst = 1'b0;
      vectors++;
      if (disp !== 16'h0000) begin $display("FAIL reset_digits: got %h want 0000", disp); miscompares++; end
      vectors++;
      if (blank !== 4'b0000) begin $display("FAIL reset_blank: got %b want 0000", blank); miscompares++; end
      vectors++;
      if (run !== 1'b1) begin $display("FAIL reset_running: got %b want 1", run); miscompares++; end
      vectors++;
      if (run2 !== 1'b0) begin $display("FAIL reset_running_start_paused: got %b want 0", run2); miscompares++; end
   endtask

   task automatic test_count_latency();
      @(negedge sys_clk) onehz_clk = 1'b1;
      #1;
      vectors++;
      if (disp !== 16'h0000) begin $display("FAIL pre_edge: got %h want 0000", disp); miscompares++; end
      @(posedge sys_clk); #1;
      vectors++;
      if (disp !== 16'h0001) begin $display("FAIL first_tick_latency: got %h want 0001", disp); miscompares++; end
      @(negedge sys_clk);
      @(negedge sys_clk);
      vectors++;
      if (disp !== 16'h0001) begin $display("FAIL level_held_no_retick: got %h want 0001", disp); miscompares++; end
      onehz_clk = 1'b0;
      tick1hz(2);
      vectors++;
      if (disp !== 16'h0003 || run !== 1'b1) begin
         $display("FAIL count_3: got %h run %b want 0003 run 1", disp, run); miscompares++;
      end
   endtask

   task automatic test_rollover();
      tick1hz(56);
      vectors++;
      if (disp !== 16'h0059) begin $display("FAIL sec_59: got %h want 0059", disp); miscompares++; end
      tick1hz(1);
      vectors++;
      if (disp !== 16'h0100) begin $display("FAIL min_carry: got %h want 0100", disp); miscompares++; end
   endtask

   task automatic test_min_wrap();
      do_reset();
      @(negedge sys_clk) pause2 = 1'b1;
      @(negedge sys_clk) pause2 = 1'b0;
      vectors++;
      if (run2 !== 1'b1) begin $display("FAIL wrap_dut_resume: got %b want 1", run2); miscompares++; end
      tick1hz(119);
      vectors++;
      if (disp2 !== 16'h0159) begin $display("FAIL wrap_0159: got %h want 0159", disp2); miscompares++; end
      tick1hz(1);
      vectors++;
      if (disp2 !== 16'h0000) begin $display("FAIL wrap_to_0000: got %h want 0000", disp2); miscompares++; end
      vectors++;
      if (disp !== 16'h0200) begin $display("FAIL no_wrap_0200: got %h want 0200", disp); miscompares++; end
   endtask

   task automatic test_pause();
      do_reset();
      tick1hz(10);
      vectors++;
      if (disp !== 16'h0010) begin $display("FAIL reach_0010: got %h want 0010", disp); miscompares++; end
      press_pause();
      tick1hz(5);
      vectors++;
      if (disp !== 16'h0010 || run !== 1'b0) begin
         $display("FAIL paused_hold: got %h run %b want 0010 run 0", disp, run); miscompares++;
      end
      press_pause();
      tick1hz(1);
      vectors++;
      if (disp !== 16'h0011 || run !== 1'b1) begin
         $display("FAIL resume: got %h run %b want 0011 run 1", disp, run); miscompares++;
      end
      @(negedge sys_clk) begin pause_btn = 1'b1; onehz_clk = 1'b1; end
      @(negedge sys_clk) begin pause_btn = 1'b0; onehz_clk = 1'b0; end
      vectors++;
      if (disp !== 16'h0012 || run !== 1'b0) begin
         $display("FAIL pause_with_tick: got %h run %b want 0012 run 0", disp, run); miscompares++;
      end
      press_pause();
   endtask

   task automatic test_adjust();
      do_reset();
      tick1hz(58);
      @(negedge sys_clk) begin adj = 1'b1; sel = 1'b1; end
      @(negedge sys_clk);
      vectors++;
      if (run !== 1'b0) begin $display("FAIL enter_adjust: running %b want 0", run); miscompares++; end
      tick2hz(3);
      vectors++;
      if (disp !== 16'h0001) begin $display("FAIL adj_sec_wrap: got %h want 0001", disp); miscompares++; end
      tick1hz(1);
      vectors++;
      if (disp !== 16'h0001) begin $display("FAIL adj_ignores_1hz: got %h want 0001", disp); miscompares++; end
      @(negedge sys_clk) blink_clk = 1'b1;
      @(negedge sys_clk);
      vectors++;
      if (blank !== 4'b0011) begin $display("FAIL blank_sec_on: got %b want 0011", blank); miscompares++; end
      blink_clk = 1'b0;
      @(negedge sys_clk);
      vectors++;
      if (blank !== 4'b0000) begin $display("FAIL blank_sec_off: got %b want 0000", blank); miscompares++; end
      sel = 1'b0;
      blink_clk = 1'b1;
      @(negedge sys_clk);
      vectors++;
      if (blank !== 4'b1100) begin $display("FAIL blank_min_on: got %b want 1100", blank); miscompares++; end
      tick2hz(1);
      vectors++;
      if (disp !== 16'h0101) begin $display("FAIL adj_min: got %h want 0101", disp); miscompares++; end
      press_pause();
      vectors++;
      if (blank !== 4'b1100 || run !== 1'b0) begin
         $display("FAIL adj_ignores_pause: blank %b run %b want 1100 run 0", blank, run); miscompares++;
      end
      adj = 1'b0;
      @(negedge sys_clk);
      vectors++;
      if (run !== 1'b0 || blank !== 4'b0000) begin
         $display("FAIL leave_adjust: run %b blank %b want run 0 blank 0000", run, blank); miscompares++;
      end
      blink_clk = 1'b0;
      press_pause();
      vectors++;
      if (run !== 1'b1) begin $display("FAIL paused_to_run: got %b want 1", run); miscompares++; end
   endtask

   task automatic test_clear();
      do_reset();
      tick1hz(150);
      vectors++;
      if (disp !== 16'h0230) begin $display("FAIL reach_0230: got %h want 0230", disp); miscompares++; end
      @(negedge sys_clk) begin clear_btn = 1'b1; onehz_clk = 1'b1; end
      @(negedge sys_clk) begin clear_btn = 1'b0; onehz_clk = 1'b0; end
      vectors++;
      if (disp !== 16'h0000 || run !== 1'b1) begin
         $display("FAIL clear_beats_tick: got %h run %b want 0000 run 1", disp, run); miscompares++;
      end
      @(negedge sys_clk) lap_btn = 1'b1;
      @(negedge sys_clk) lap_btn = 1'b0;
      tick1hz(2);
      vectors++;
      if (disp !== 16'h0002) begin $display("FAIL live_after_lap_btn: got %h want 0002", disp); miscompares++; end
   endtask

   task automatic test_reset_mid_adjust();
      do_reset();
      @(negedge sys_clk) begin adj = 1'b1; sel = 1'b0; end
      tick2hz(5);
      sel = 1'b1;
      tick2hz(42);
      blink_clk = 1'b1;
      @(negedge sys_clk);
      vectors++;
      if (disp !== 16'h0542 || blank !== 4'b0011) begin
         $display("FAIL reach_0542: got %h blank %b want 0542 blank 0011", disp, blank); miscompares++;
      end
      rst = 1'b1;
      @(posedge sys_clk); #1;
      vectors++;
      if (disp !== 16'h0000 || blank !== 4'b0000 || run !== 1'b1) begin
         $display("FAIL rst_in_adjust: got %h blank %b run %b want 0000 0000 1", disp, blank, run);
         miscompares++;
      end
      vectors++;
      if (run2 !== 1'b0 || disp2 !== 16'h0000) begin
         $display("FAIL rst_start_paused: run %b digits %h want run 0 digits 0000", run2, disp2);
         miscompares++;
      end
      @(negedge sys_clk) begin rst = 1'b0; adj = 1'b0; sel = 1'b0; blink_clk = 1'b0; end
   endtask

   initial begin
      test_reset();
      test_count_latency();
      test_rollover();
      test_min_wrap();
      test_pause();
      test_adjust();
      test_clear();
      test_reset_mid_adjust();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
